tcdm_interconnect_xbar: RTL and testbench
=========================================

// Module: tcdm_interconnect_xbar
// PURPOSE
//  Single-stage, fully connected crossbar between NumIn TCDM masters (core data ports) and
//  NumOut TCDM banks. Routes requests by word-interleaved bank index.
//  Arbitrates contending masters per bank with round-robin.
//  Routes 1-cycle-latency bank read data back to the issuing master.
//  Instantiated once per banking slice inside the cluster.
// PARAMETERS
//  NumIn        256  number of master ports (power of 2, >=2)
//  NumOut       256  number of bank ports (power of 2, >=2)
//  AddrWidth    32   master byte-address width
//  DataWidth    32   data width; BeWidth = DataWidth/8; ByteOff = log2(BeWidth)
//  AddrMemWidth 12   bank-local word-address width
//  WriteRespOn  0    1: writes also return vld_o; 0: only reads do
// PORTS
//  clk_i    in  1                      clock
//  rst_ni   in  1                      async reset, active low
//  req_i    in  NumIn                  master request
//  add_i    in  NumIn x AddrWidth      byte address
//  wen_i    in  NumIn                  1=write, 0=read
//  wdata_i  in  NumIn x DataWidth      write data
//  be_i     in  NumIn x BeWidth        byte enables
//  gnt_o    out NumIn                  request accepted this cycle
//  vld_o    out NumIn                  response valid (cycle after grant)
//  rdata_o  out NumIn x DataWidth      read data, meaningful when vld_o=1
//  req_o    out NumOut                 bank request
//  gnt_i    in  NumOut                 bank ready (tie 1 for SRAM banks)
//  add_o    out NumOut x AddrMemWidth  bank word address
//  wen_o    out NumOut                 bank write enable
//  wdata_o  out NumOut x DataWidth     bank write data
//  be_o     out NumOut x BeWidth       bank byte enables
//  rdata_i  in  NumOut x DataWidth     bank read data, valid 1 cycle after req_o&gnt_i
// BEHAVIOUR
//  - Clocking: single clock domain on clk_i.
//  - Bank select:
//    - bank = add_i[ByteOff +: log2(NumOut)]
//    - add_o = add_i[ByteOff+log2(NumOut) +: AddrMemWidth]
//    - Higher address bits are ignored.
//  - Per-bank arbitration (combinational):
//    - Round-robin among masters with req_i=1 targeting that bank.
//    - Winner's add/wen/wdata/be drive the bank.
//    - req_o = any requester present.
//    - With no requester: add_o, wen_o, wdata_o and be_o are 0.
//  - Grant:
//    - gnt_o[m] = 1 iff m is the winner of its bank AND that bank's gnt_i = 1.
//    - gnt_o is purely combinational.
//    - A master holds its request until granted.
//  - RR pointer:
//    - One per bank.
//    - On a handshake (req_o & gnt_i) it moves to winner+1 (mod NumIn).
//    - Otherwise it is unchanged.
//    - Priority search starts at the pointer.
//  - Response:
//    - On a handshake, register the winner index and the flag rsp = (!wen | WriteRespOn).
//    - Next cycle: vld_o[winner] = rsp and rdata_o[winner] = rdata_i[bank].
//    - Read latency is exactly 1 cycle after gnt_o, and responses stay in order.
//    - Banks may accept every cycle, giving back-to-back responses.
//    - A master can receive at most one response per cycle.
//    - rdata_o is 0 when vld_o = 0.
//  - Reset:
//    - All RR pointers reset to 0.
//    - All response registers are cleared, so vld_o = 0.
//    - Combinational outputs follow the inputs immediately.
//    - Reset mid-transaction drops the pending response; no vld_o is issued.
// TESTING
//  - Reset, req_i=0 -> vld_o=0, req_o=0, gnt_o=0.
//  - Read, single master:
//    - Stimulus: master 3 reads add=0x0000_1008 (NumOut=4, DataWidth=32).
//    - Bank 2 sees add_o=0x100. gnt_o[3] same cycle.
//    - Next cycle: vld_o[3]=1, rdata_o[3]=rdata_i[2].
//  - Round-robin contention:
//    - Stimulus: masters 0 and 1 hold reads to bank 0 for 4 cycles.
//    - Grants alternate 0,1,0,1; each vld_o follows 1 cycle after its grant.
//  - Bank stall:
//    - Stimulus: gnt_i[1]=0 for 3 cycles while master 2 requests bank 1.
//    - gnt_o[2]=0, req_o[1]=1 for those cycles.
//    - Grant occurs on the cycle gnt_i[1] rises; the pointer does not move while stalled.
//  - Write, WriteRespOn=0:
//    - Stimulus: master 0 writes wdata=0xDEADBEEF, be=0x3.
//    - Bank gets wen_o=1, wdata_o=0xDEADBEEF, be_o=0x3; gnt_o[0]=1; no vld_o follows.
//    - Same stimulus with WriteRespOn=1: vld_o[0]=1 next cycle.
//  - Parallel and reset:
//    - Stimulus: NumIn masters each target a distinct bank.
//    - All granted in one cycle; all vld_o high next cycle.
//    - Assert rst_ni low between grant and response -> vld_o stays 0.

Source files
------------

// File: rtl/tcdm_interconnect_xbar_if.sv
// TCDM request/response bundle: one lane per port, master drives requests, slave answers.
interface tcdm_interconnect_xbar_if #(
    parameter int unsigned N         = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned BeWidth = DataWidth / 8;

    logic [N-1:0]                req;
    logic [N-1:0][AddrWidth-1:0] add;
    logic [N-1:0]                wen;
    logic [N-1:0][DataWidth-1:0] wdata;
    logic [N-1:0][BeWidth-1:0]   be;
    logic [N-1:0]                gnt;
    logic [N-1:0]                vld;
    logic [N-1:0][DataWidth-1:0] rdata;

    modport master (
        output req, add, wen, wdata, be,
        input  gnt, vld, rdata
    );

    modport slave (
        input  req, add, wen, wdata, be,
        output gnt, vld, rdata
    );
endinterface

// File: rtl/tcdm_interconnect_xbar.sv
// Fully connected TCDM crossbar: word-interleaved bank select, per-bank round-robin arbitration,
// one-cycle read response routed back to the granted master.
module tcdm_interconnect_xbar #(
    parameter int unsigned NumIn        = 256,
    parameter int unsigned NumOut       = 256,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddrMemWidth = 12,
    parameter bit          WriteRespOn  = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    tcdm_interconnect_xbar_if.slave  mst,
    tcdm_interconnect_xbar_if.master bank
);
    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned ByteOff = $clog2(BeWidth);
    localparam int unsigned BankW   = $clog2(NumOut);
    localparam int unsigned IdxW    = $clog2(NumIn);

    logic [NumIn-1:0][BankW-1:0]      sel;
    logic [NumOut-1:0][IdxW-1:0]      win;
    logic [NumOut-1:0]                found;
    logic [NumOut-1:0]                hs;
    logic [NumOut-1:0][IdxW-1:0]      ptr_q, ptr_d;
    logic [NumOut-1:0][IdxW-1:0]      rsp_idx_q, rsp_idx_d;
    logic [NumOut-1:0]                rsp_vld_q, rsp_vld_d;

    logic [NumOut-1:0]                   bank_req;
    logic [NumOut-1:0][AddrMemWidth-1:0] bank_add;
    logic [NumOut-1:0]                   bank_wen;
    logic [NumOut-1:0][DataWidth-1:0]    bank_wdata;
    logic [NumOut-1:0][BeWidth-1:0]      bank_be;
    logic [NumIn-1:0]                    gnt;
    logic [NumIn-1:0]                    vld;
    logic [NumIn-1:0][DataWidth-1:0]     rdata;

    always_comb begin
        for (int m = 0; m < NumIn; m++) begin
            sel[m] = mst.add[m][ByteOff +: BankW];
        end
    end

    // First requester found scanning upward from the bank's pointer wins.
    always_comb begin
        logic [IdxW-1:0] idx;
        idx   = '0;
        win   = '0;
        found = '0;
        for (int b = 0; b < NumOut; b++) begin
            for (int k = 0; k < NumIn; k++) begin
                idx = ptr_q[b] + IdxW'(k);
                if (!found[b] && mst.req[idx] && (sel[idx] == BankW'(b))) begin
                    win[b]   = idx;
                    found[b] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bank_req   = '0;
        bank_add   = '0;
        bank_wen   = '0;
        bank_wdata = '0;
        bank_be    = '0;
        for (int b = 0; b < NumOut; b++) begin
            if (found[b]) begin
                bank_req[b]   = 1'b1;
                bank_add[b]   = mst.add[win[b]][ByteOff+BankW +: AddrMemWidth];
                bank_wen[b]   = mst.wen[win[b]];
                bank_wdata[b] = mst.wdata[win[b]];
                bank_be[b]    = mst.be[win[b]];
            end
        end
    end

    assign hs = found & bank.gnt;

    always_comb begin
        gnt       = '0;
        ptr_d     = ptr_q;
        rsp_idx_d = rsp_idx_q;
        rsp_vld_d = '0;
        for (int b = 0; b < NumOut; b++) begin
            if (hs[b]) begin
                gnt[win[b]]  = 1'b1;
                ptr_d[b]     = win[b] + IdxW'(1);
                rsp_idx_d[b] = win[b];
                rsp_vld_d[b] = ~bank_wen[b] | WriteRespOn;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            rsp_idx_q <= '0;
            rsp_vld_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rsp_idx_q <= rsp_idx_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end

    // A master is granted by at most one bank per cycle, so responses never collide.
    always_comb begin
        vld   = '0;
        rdata = '0;
        for (int b = 0; b < NumOut; b++) begin
            if (rsp_vld_q[b]) begin
                vld[rsp_idx_q[b]]   = 1'b1;
                rdata[rsp_idx_q[b]] = bank.rdata[b];
            end
        end
    end

    assign mst.gnt    = gnt;
    assign mst.vld    = vld;
    assign mst.rdata  = rdata;
    assign bank.req   = bank_req;
    assign bank.add   = bank_add;
    assign bank.wen   = bank_wen;
    assign bank.wdata = bank_wdata;
    assign bank.be    = bank_be;
endmodule

// File: tb/tb_tcdm_interconnect_xbar.sv
// Bench for tcdm_interconnect_xbar: directed scenarios then random traffic against a
// cycle-level reference model; two DUTs share stimulus and differ only in WriteRespOn.
module tb_tcdm_interconnect_xbar;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 12;
    localparam int BW = DW / 8;
    localparam int BO = 2;
    localparam int BKW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    tcdm_interconnect_xbar_if #(.N(NI), .AddrWidth(AW), .DataWidth(DW)) core0 ();
    tcdm_interconnect_xbar_if #(.N(NI), .AddrWidth(AW), .DataWidth(DW)) core1 ();
    tcdm_interconnect_xbar_if #(.N(NO), .AddrWidth(MW), .DataWidth(DW)) bank0 ();
    tcdm_interconnect_xbar_if #(.N(NO), .AddrWidth(MW), .DataWidth(DW)) bank1 ();

    assign core1.req   = core0.req;
    assign core1.add   = core0.add;
    assign core1.wen   = core0.wen;
    assign core1.wdata = core0.wdata;
    assign core1.be    = core0.be;
    assign bank1.gnt   = bank0.gnt;
    assign bank1.rdata = bank0.rdata;
    assign bank0.vld   = '0;
    assign bank1.vld   = '0;

    tcdm_interconnect_xbar #(
        .NumIn(NI), .NumOut(NO), .AddrWidth(AW), .DataWidth(DW), .AddrMemWidth(MW),
        .WriteRespOn(1'b0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .mst(core0.slave), .bank(bank0.master)
    );

    tcdm_interconnect_xbar #(
        .NumIn(NI), .NumOut(NO), .AddrWidth(AW), .DataWidth(DW), .AddrMemWidth(MW),
        .WriteRespOn(1'b1)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .mst(core1.slave), .bank(bank1.master)
    );

    always #5 clk = ~clk;

    // Reference model state
    int ptr[NO];
    int n_ptr[NO];
    logic [NI-1:0] pv0, pv1, n_v0, n_v1, last_gnt;
    int pbank[NI];
    int n_bank[NI];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic eval();
        logic [NI-1:0] e_gnt;
        logic [NO-1:0] e_req, e_wen;
        logic [NO-1:0][MW-1:0] e_add;
        logic [NO-1:0][DW-1:0] e_wd;
        logic [NO-1:0][BW-1:0] e_be;
        logic [NI-1:0][DW-1:0] e_rd0, e_rd1;
        int w, m;
        if (!rst_n) begin
            pv0 = '0;
            pv1 = '0;
            for (int b = 0; b < NO; b++) ptr[b] = 0;
        end
        for (int b = 0; b < NO; b++) bank0.rdata[b] = $urandom;
        #1;
        e_rd0 = '0;
        e_rd1 = '0;
        for (int i = 0; i < NI; i++) begin
            if (pv0[i]) e_rd0[i] = bank0.rdata[pbank[i]];
            if (pv1[i]) e_rd1[i] = bank0.rdata[pbank[i]];
        end
        chk("vld0", core0.vld, pv0);
        chk("vld1", core1.vld, pv1);
        chk("rdata0", core0.rdata, e_rd0);
        chk("rdata1", core1.rdata, e_rd1);

        e_gnt = '0; e_req = '0; e_wen = '0; e_add = '0; e_wd = '0; e_be = '0;
        n_v0 = '0; n_v1 = '0;
        for (int i = 0; i < NI; i++) n_bank[i] = pbank[i];
        for (int b = 0; b < NO; b++) begin
            n_ptr[b] = ptr[b];
            w = -1;
            for (int k = 0; k < NI && w < 0; k++) begin
                m = (ptr[b] + k) % NI;
                if (core0.req[m] && ((core0.add[m] >> BO) % NO) == b) w = m;
            end
            if (w >= 0) begin
                e_req[b] = 1'b1;
                e_add[b] = MW'((core0.add[w] >> (BO + BKW)) & 32'hFFF);
                e_wen[b] = core0.wen[w];
                e_wd[b]  = core0.wdata[w];
                e_be[b]  = core0.be[w];
                if (bank0.gnt[b]) begin
                    e_gnt[w]  = 1'b1;
                    n_v0[w]   = !core0.wen[w];
                    n_v1[w]   = 1'b1;
                    n_bank[w] = b;
                    n_ptr[b]  = (w + 1) % NI;
                end
            end
        end
        chk("gnt0", core0.gnt, e_gnt);
        chk("gnt1", core1.gnt, e_gnt);
        chk("req_o", bank0.req, e_req);
        chk("add_o", bank0.add, e_add);
        chk("wen_o", bank0.wen, e_wen);
        chk("wdata_o", bank0.wdata, e_wd);
        chk("be_o", bank0.be, e_be);
        chk("req_o1", bank1.req, e_req);
        last_gnt = e_gnt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            pv0 = n_v0;
            pv1 = n_v1;
            for (int i = 0; i < NI; i++) pbank[i] = n_bank[i];
            for (int b = 0; b < NO; b++) ptr[b] = n_ptr[b];
        end else begin
            pv0 = '0;
            pv1 = '0;
            for (int b = 0; b < NO; b++) ptr[b] = 0;
        end
        #1;
    endtask

    task automatic idle();
        core0.req = '0; core0.add = '0; core0.wen = '0; core0.wdata = '0; core0.be = '0;
    endtask

    task automatic set_req(input int m, input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
        core0.req[m] = 1'b1; core0.add[m] = a; core0.wen[m] = w;
        core0.wdata[m] = d; core0.be[m] = be;
    endtask

    initial begin
        pv0 = '0; pv1 = '0; last_gnt = '0;
        for (int b = 0; b < NO; b++) ptr[b] = 0;
        for (int i = 0; i < NI; i++) pbank[i] = 0;
        idle();
        bank0.gnt = '1;
        bank0.rdata = '0;

        // Reset with no requests
        eval();
        chk("rst_req_o", bank0.req, '0);
        chk("rst_gnt", core0.gnt, '0);
        chk("rst_vld", core0.vld, '0);
        tick();
        rst_n = 1'b1;

        // Single read: master 3 -> bank 2, word 0x100
        set_req(3, 32'h0000_1008, 1'b0, '0, '0);
        eval();
        chk("rd_gnt3", core0.gnt[3], 1'b1);
        chk("rd_add2", bank0.add[2], 12'h100);
        tick();
        idle();
        eval();
        chk("rd_vld3", core0.vld[3], 1'b1);
        chk("rd_data3", core0.rdata[3], bank0.rdata[2]);
        tick();

        // Round-robin contention on bank 0
        for (int c = 0; c < 4; c++) begin
            idle();
            set_req(0, 32'h0000_0000, 1'b0, '0, '0);
            set_req(1, 32'h0000_0040, 1'b0, '0, '0);
            eval();
            chk("rr_gnt", core0.gnt, (c % 2 == 0) ? 4'b0001 : 4'b0010);
            tick();
        end
        idle();
        eval();
        tick();

        // Bank 1 stalls for three cycles while master 2 waits
        bank0.gnt[1] = 1'b0;
        set_req(2, 32'h0000_0004, 1'b0, '0, '0);
        for (int c = 0; c < 3; c++) begin
            eval();
            chk("stall_gnt2", core0.gnt[2], 1'b0);
            chk("stall_req1", bank0.req[1], 1'b1);
            tick();
        end
        bank0.gnt[1] = 1'b1;
        eval();
        chk("stall_rel_gnt2", core0.gnt[2], 1'b1);
        tick();
        idle();

        // Write from master 0: response only on the WriteRespOn instance
        set_req(0, 32'h0000_0020, 1'b1, 32'hDEAD_BEEF, 4'h3);
        eval();
        chk("wr_wen", bank0.wen[0], 1'b1);
        chk("wr_wdata", bank0.wdata[0], 32'hDEAD_BEEF);
        chk("wr_be", bank0.be[0], 4'h3);
        chk("wr_gnt0", core0.gnt[0], 1'b1);
        tick();
        idle();
        eval();
        chk("wr_novld", core0.vld[0], 1'b0);
        chk("wr_vld_on", core1.vld[0], 1'b1);
        tick();

        // All masters to distinct banks, then reset before the responses land
        for (int m = 0; m < NI; m++) set_req(m, (AW'($urandom) << 4) | AW'(m * 4), 1'b0, '0, '0);
        eval();
        chk("par_gnt", core0.gnt, 4'hF);
        tick();
        eval();
        chk("par_vld", core0.vld, 4'hF);
        chk("par_gnt2", core0.gnt, 4'hF);
        rst_n = 1'b0;
        tick();
        idle();
        eval();
        chk("rst_mid_vld0", core0.vld, '0);
        chk("rst_mid_vld1", core1.vld, '0);
        tick();
        rst_n = 1'b1;

        // Random traffic; a master keeps its request until the model says it was granted
        for (int c = 0; c < 300; c++) begin
            for (int m = 0; m < NI; m++) begin
                if (!(core0.req[m] && !last_gnt[m])) begin
                    set_req(m, AW'($urandom), 1'($urandom), DW'($urandom), BW'($urandom));
                    core0.req[m] = ($urandom_range(0, 3) != 0);
                end
            end
            for (int b = 0; b < NO; b++) bank0.gnt[b] = ($urandom_range(0, 4) != 0);
            eval();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
